// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed-latency valid/ready request path and a one-cycle response.
// Defining DMEM_ALIGN_CHECK_EN flags misaligned accesses and suppresses their effect.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        rw,
  input  logic [31:0] index,
  input  logic [31:0] inputMem,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            rw_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            mis_q;
  logic            err_q;
  logic            mis_in;
  logic            accept;
  logic            access;
  logic [31:0]     mem [DEPTH];
  logic            unused_index;

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_in = |index[1:0];
`else
  assign mis_in = 1'b0;
`endif

  assign unused_index = ^{index[31:AW+2], index[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = WAIT;
      WAIT: if (cnt == '0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    accept    = (state == IDLE) && req_valid;
    access    = (state == WAIT) && (cnt == '0);
    rsp_err   = (state == RESP) && err_q;
  end

  // Request fields are frozen at accept so later input changes cannot affect the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        cnt     <= CW'(LATENCY - 1);
        rw_q    <= rw;
        addr_q  <= index[AW+1:2];
        wdata_q <= inputMem;
        mis_q   <= mis_in;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (access) begin
        err_q <= mis_q;
        if (!rw_q && !mis_q) rdata <= mem[addr_q];
      end
    end
  end

  // Array has no reset; a write aborted by reset never reaches the access edge.
  always_ff @(posedge clk) begin
    if (access && rw_q && !mis_q) mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued at request time and
// compared when rsp_valid pulses; honours DMEM_ALIGN_CHECK_EN when the build defines it.
module tb_dmem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        rw;
  logic [31:0] index;
  logic [31:0] inputMem;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] memModel [DEPTH];
  logic [31:0] rdataModel;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          respCount = 0;
  int          pushCount = 0;
  logic        prevValid = 1'b0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .rw(rw), .index(index), .inputMem(inputMem), .rsp_valid(rsp_valid),
    .rdata(rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic pushExpected(input logic wr, input logic [31:0] idx, input logic [31:0] data,
                              input int acc);
    exp_t e;
    logic mis;
    logic [7:0] w;
    w = idx[9:2];
`ifdef DMEM_ALIGN_CHECK_EN
    mis = |idx[1:0];
`else
    mis = 1'b0;
`endif
    if (!mis) begin
      if (wr) memModel[w] = data;
      else    rdataModel = memModel[w];
    end
    e.rdata = rdataModel;
    e.err   = mis;
    e.acc   = acc;
    expq.push_back(e);
    pushCount++;
  endtask

  // Response monitor: pops one expectation per pulse and checks data, flag, latency and width.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      respCount++;
      if (prevValid) checkOutput("pulse_width", 32'd1, 32'd0);
      if (expq.size() == 0) begin
        checkOutput("spurious_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checkOutput("rdata", rdata, e.rdata);
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        checkOutput("latency", cyc - e.acc, LATENCY);
      end
    end
    prevValid = rst_n && rsp_valid;
  end

  task automatic waitDrain();
    int n = 0;
    while (expq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      checkOutput("drain_timeout", expq.size(), 0);
      expq.delete();
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] idx, input logic [31:0] data);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) checkOutput("ready_timeout", 0, 1);
    rw = wr; index = idx; inputMem = data; req_valid = 1'b1;
    pushExpected(wr, idx, data, cyc + 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rw = $urandom_range(0, 1);
    index = $urandom;
    inputMem = $urandom;
    waitDrain();
  endtask

  logic        b2bRw   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] b2bIdx  [6] = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h40, 32'h44};
  logic [31:0] b2bData [6] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'h0, 32'h0, 32'hC3C3C3C3, 32'h0};

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rw = 1'b0; index = '0; inputMem = '0;
    rdataModel = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Store then load, then address wrap.
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 32'h400, 32'h00000001);
    applyStimulus(1'b0, 32'h000, 32'h0);

    // Back-to-back with req_valid held high.
    begin
      int k = 0, guard = 0, lowCnt = 0, prevAcc = 0;
      @(negedge clk);
      rw = b2bRw[0]; index = b2bIdx[0]; inputMem = b2bData[0]; req_valid = 1'b1;
      while (k < 6 && guard < 200) begin
        guard++;
        if (req_ready) begin
          if (k > 0) begin
            checkOutput("ready_low", lowCnt, LATENCY + 1);
            checkOutput("accept_gap", cyc + 1 - prevAcc, LATENCY + 2);
          end
          prevAcc = cyc + 1;
          pushExpected(b2bRw[k], b2bIdx[k], b2bData[k], cyc + 1);
          k++;
          lowCnt = 0;
          @(posedge clk);
          #1;
          if (k < 6) begin
            rw = b2bRw[k]; index = b2bIdx[k]; inputMem = b2bData[k];
          end else begin
            req_valid = 1'b0;
          end
        end else begin
          lowCnt++;
        end
        @(negedge clk);
      end
      req_valid = 1'b0;
      if (k < 6) checkOutput("b2b_timeout", k, 6);
      waitDrain();
      checkOutput("rsp_count", respCount, pushCount);
    end

    // Reset during WAIT aborts the write.
    applyStimulus(1'b1, 32'h20, 32'h000000AA);
    rw = 1'b1; index = 32'h20; inputMem = 32'h00000055; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("midrst_rdata", rdata, 32'h0);
    rdataModel = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h20, 32'h0);

    // Reset asserted during RESP drops rsp_valid at once.
    begin
      int n = 0;
      @(negedge clk);
      rw = 1'b0; index = 32'h10; inputMem = '0; req_valid = 1'b1;
      pushExpected(1'b0, 32'h10, 32'h0, cyc + 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("resp_rst_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("resp_rst_rdata", rdata, 32'h0);
      expq.delete();
      rdataModel = '0;
      @(negedge clk);
      rst_n = 1'b1;
    end

    // Misaligned write, then read back the containing word and a misaligned read.
    applyStimulus(1'b1, 32'h13, 32'h12345678);
    applyStimulus(1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 32'h11, 32'h0);

    checkOutput("final_queue", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
